// File: rtl/bidir_port_ctrl.sv
// bidir_port_ctrl
//   Bidirectional port controller for a shared tri-state bus. It can either
//   drive dataBus from an output register (transmit) or sample dataBus into a
//   receive FIFO. Every change of direction passes through a float phase of
//   TURNAROUND cycles, so this block and the far-end driver never overlap.
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   dataBus                 shared tri-state bus (WIDTH)
//   dir                     0 = drive request, 1 = receive request
//   bus_strobe              sample dataBus at this edge (RECV only)
//   tx_data/valid/ready     transmit handshake; tx_ready only in DRIVE
//   rx_data/valid/ready     FIFO head, first-word fall-through
//   clear_ovf, overflow     sticky dropped-word flag and its clear
//   drive_en                high while dataBus is driven by this block
//   rx_count                FIFO occupancy, 0..DEPTH
`timescale 1ns/1ps
module bidir_port_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    inout  wire  [WIDTH-1:0]           dataBus,
    input  logic                       dir,
    input  logic                       bus_strobe,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    input  logic                       clear_ovf,
    output logic                       overflow,
    output logic                       drive_en,
    output logic [$clog2(DEPTH):0]     rx_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TURNAROUND + 1);
    localparam logic [TW-1:0] TURN_RELOAD = TW'(TURNAROUND);

    typedef enum logic [1:0] {FLOAT, DRIVE, RECV} state_t;

    state_t                        state_q, state_d;
    logic [TW-1:0]                 turn_q, turn_d;
    logic [WIDTH-1:0]              out_q, out_d;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          ovf_q, ovf_d;

    logic push_req, push_ok, pop, drop;

    // The bus follows the registered state, so an async reset releases it at once.
    assign drive_en = (state_q == DRIVE);
    assign tx_ready = drive_en;
    assign dataBus  = drive_en ? out_q : {WIDTH{1'bz}};

    assign rx_valid = (count_q != '0);
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_count = count_q;
    assign overflow = ovf_q;

    assign pop      = rx_valid && rx_ready;
    assign push_req = (state_q == RECV) && bus_strobe;
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push_ok  = push_req && ((count_q < CW'(DEPTH)) || pop);
    assign drop     = push_req && !push_ok;

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            FLOAT: begin
                // FLOAT lasts exactly TURNAROUND cycles; dir is only looked at on the last one.
                if (turn_q <= TW'(1)) begin
                    state_d = dir ? RECV : DRIVE;
                    turn_d  = TURN_RELOAD;
                end else begin
                    turn_d  = turn_q - TW'(1);
                end
            end
            DRIVE: if (dir) begin
                state_d = FLOAT;
                turn_d  = TURN_RELOAD;
            end
            RECV: if (!dir) begin
                state_d = FLOAT;
                turn_d  = TURN_RELOAD;
            end
            default: begin
                state_d = FLOAT;
                turn_d  = TURN_RELOAD;
            end
        endcase
    end

    always_comb begin
        out_d    = out_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (tx_valid && tx_ready) out_d = tx_data;

        if (push_ok) begin
            mem_d[wr_ptr_q] = dataBus;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new drop wins over a clear on the same edge.
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= FLOAT;
            turn_q   <= TURN_RELOAD;
            out_q    <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            out_q    <= out_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_bidir_port_ctrl.sv
// tb_bidir_port_ctrl
//   Directed bench for bidir_port_ctrl (WIDTH=8, DEPTH=4, TURNAROUND=1).
//   Inputs change 1 ns after a rising edge; outputs are checked there too.
`timescale 1ns/1ps
module tb_bidir_port_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    wire  [7:0] dataBus;
    logic       dir, bus_strobe, tx_valid, rx_ready, clear_ovf;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, overflow, drive_en;
    logic [7:0] rx_data;
    logic [2:0] rx_count;

    logic       tb_drv_en;
    logic [7:0] tb_drv;
    assign dataBus = tb_drv_en ? tb_drv : 8'bz;

    int n_cmp = 0;
    int n_err = 0;

    bidir_port_ctrl #(.WIDTH(8), .DEPTH(4), .TURNAROUND(1)) dut (
        .clock(clock), .reset(reset), .dataBus(dataBus), .dir(dir),
        .bus_strobe(bus_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .clear_ovf(clear_ovf), .overflow(overflow),
        .drive_en(drive_en), .rx_count(rx_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one word from the far end while in RECV.
    task automatic strobe_word(input logic [7:0] w, input logic do_pop);
        tb_drv_en = 1'b1; tb_drv = w; bus_strobe = 1'b1; rx_ready = do_pop;
        step();
        tb_drv_en = 1'b0; bus_strobe = 1'b0; rx_ready = 1'b0;
    endtask

    // Check the head word then pop it.
    task automatic pop_check(input string tag, input logic [7:0] w);
        chk(tag, rx_data, w);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dir = 1'b0; bus_strobe = 1'b0; tx_valid = 1'b0;
        rx_ready = 1'b0; clear_ovf = 1'b0; tx_data = 8'h00;
        tb_drv_en = 1'b0; tb_drv = 8'h00;
        repeat (3) step();

        // Reset state
        chk("rst_drive_en", drive_en, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data",  rx_data,  0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rx_count", rx_count, 0);

        // 1: one float cycle after release, then DRIVE with out register 00
        reset = 1'b0;
        chk("t1_float_drive_en", drive_en, 0);
        step();
        chk("t1_drive_en", drive_en, 1);
        chk("t1_tx_ready", tx_ready, 1);
        chk("t1_bus", dataBus, 8'h00);

        // 2: single transfer, value held after tx_valid drops
        tx_data = 8'hA5; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0; tx_data = 8'h11;
        chk("t2_bus", dataBus, 8'hA5);
        step();
        chk("t2_bus_hold", dataBus, 8'hA5);

        // 3: turn to receive; exactly one float cycle
        dir = 1'b1;
        step();
        chk("t3_float_drive_en", drive_en, 0);
        chk("t3_float_tx_ready", tx_ready, 0);
        strobe_word(8'h77, 1'b0);     // lands in FLOAT: ignored
        chk("t3_float_no_push", rx_count, 0);
        chk("t3_float_no_ovf", overflow, 0);
        chk("t3_recv_drive_en", drive_en, 0);
        strobe_word(8'h3C, 1'b0);
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rx_data",  rx_data, 8'h3C);
        chk("t3_rx_count", rx_count, 1);
        pop_check("t3_pop", 8'h3C);
        chk("t3_empty", rx_valid, 0);

        // 4: five strobes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) strobe_word(8'(i), 1'b0);
        chk("t4_count", rx_count, 4);
        chk("t4_overflow", overflow, 1);
        for (int i = 1; i <= 4; i++) pop_check("t4_pop", 8'(i));
        chk("t4_drained", rx_count, 0);
        chk("t4_ovf_sticky", overflow, 1);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("t4_ovf_clear", overflow, 0);

        // 5: full FIFO, push with simultaneous pop
        for (int i = 0; i < 4; i++) strobe_word(8'h10 + 8'(i), 1'b0);
        strobe_word(8'h14, 1'b1);
        chk("t5_count", rx_count, 4);
        chk("t5_ovf", overflow, 0);
        for (int i = 1; i <= 4; i++) pop_check("t5_pop", 8'h10 + 8'(i));
        // pointer wrap over three fill/drain rounds
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) strobe_word(8'h20 + 8'(k*16 + i), 1'b0);
            chk("t5_wrap_full", rx_count, 4);
            for (int i = 0; i < 4; i++) pop_check("t5_wrap_pop", 8'h20 + 8'(k*16 + i));
            chk("t5_wrap_empty", rx_count, 0);
        end

        // Drop and clear on the same edge: set wins
        for (int i = 0; i < 4; i++) strobe_word(8'h40 + 8'(i), 1'b0);
        clear_ovf = 1'b1;
        strobe_word(8'h44, 1'b0);
        clear_ovf = 1'b0;
        chk("set_wins_ovf", overflow, 1);
        chk("set_wins_count", rx_count, 4);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("set_wins_clear", overflow, 0);
        pop_check("pre6_pop0", 8'h40);
        pop_check("pre6_pop1", 8'h41);

        // Back to DRIVE: out register re-driven, FIFO preserved, strobe ignored
        dir = 1'b0;
        step();
        chk("back_float", drive_en, 0);
        step();
        chk("back_drive_en", drive_en, 1);
        chk("back_bus", dataBus, 8'hA5);
        bus_strobe = 1'b1; step(); bus_strobe = 1'b0;
        chk("drive_strobe_count", rx_count, 2);
        chk("drive_strobe_ovf", overflow, 0);
        chk("drive_fifo_head", rx_data, 8'h42);

        // 6: async reset mid-DRIVE
        #2 reset = 1'b1;
        #1;
        chk("t6_drive_en", drive_en, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_rx_count", rx_count, 0);
        dir = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_float", drive_en, 0);
        step();
        strobe_word(8'h99, 1'b0);
        chk("t6_recv_push", rx_count, 1);
        chk("t6_recv_data", rx_data, 8'h99);
        dir = 1'b0;
        step(); step();
        chk("t6_drive_en2", drive_en, 1);
        chk("t6_out_reset", dataBus, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
